// File: rtl/ps2_kbd_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard receiver:
//                event record, prefix byte codes, frame-state encoding and
//                the frame acceptance check.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   // Prefix bytes that modify the next scan code instead of producing events
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // One decoded key event as stored in the event FIFO
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   // Frame receiver states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } ps2_frame_state_t;

   // Odd parity over data+parity and a high stop bit make a valid frame
   function automatic logic frame_ok(input logic [7:0] data,
                                     input logic       parity,
                                     input logic       stop);
      return (^{data, parity}) & stop;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : First-word fall-through FIFO of ps2_event_t entries.
//                A push while full is dropped (drop pulse) unless a pop
//                happens in the same cycle. Storage is reset so the head
//                reads as zero out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  ps2_event_t               push_data,
   input  logic                     pop,
   output ps2_event_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int c_AW = $clog2(DEPTH);

   ps2_event_t         r_mem [DEPTH];
   logic [c_AW-1:0]    r_wr_ptr;
   logic [c_AW-1:0]    r_rd_ptr;
   logic [c_AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_full    = (r_count == (c_AW+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = pop & ~w_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_do_push = push & (~w_full | w_do_pop);
   assign drop      = push & w_full & ~w_do_pop;

   // Storage, pointers (wrap modulo DEPTH) and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver. Synchronises ps2_clk/ps2_data,
//                deserialises 11-bit frames on ps2_clk falling edges, folds
//                E0/F0 prefixes into make/break events and queues them in a
//                first-word fall-through FIFO. Sticky overflow and
//                frame_err flags, cleared by clr_err.
//                Optional: define PS2_KBD_RX_DEGLITCH_EN to require the
//                synchronised ps2_clk level to be stable for 4 clk cycles
//                before it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 5000,
   parameter int SYNC_STAGES = 3
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_brk,
   output logic                          ev_ext,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clr_err
);

   localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   w_fall;
   logic                   w_data;

   ps2_frame_state_t       r_state;
   logic [3:0]             r_bit_cnt;
   logic [c_TO_W-1:0]      r_to_cnt;
   logic [7:0]             r_shift;
   logic                   r_parity;
   logic                   r_stop;
   logic                   r_ext_pend;
   logic                   r_brk_pend;
   logic                   r_push;
   ps2_event_t             r_push_data;
   logic                   r_frame_err;
   logic                   r_overflow;

   ps2_event_t             w_head;
   logic                   w_drop;
   logic                   w_pop;

   // Synchronisers reset high so an idle bus never looks like an edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign w_data = r_data_sync[SYNC_STAGES-1];

`ifdef PS2_KBD_RX_DEGLITCH_EN
   logic       r_clk_filt;
   logic       r_clk_filt_d;
   logic [1:0] r_dg_cnt;

   // Accept a new ps2_clk level only after 4 consecutive cycles of it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_dg_cnt     <= '0;
      end else begin
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_sync[SYNC_STAGES-1] == r_clk_filt) begin
            r_dg_cnt <= '0;
         end else if (r_dg_cnt == 2'd3) begin
            r_clk_filt <= r_clk_sync[SYNC_STAGES-1];
            r_dg_cnt   <= '0;
         end else begin
            r_dg_cnt <= r_dg_cnt + 1'b1;
         end
      end
   end

   assign w_fall = r_clk_filt_d & ~r_clk_filt;
`else
   assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
`endif

   // Frame FSM: start/data/parity/stop capture, checking, prefix folding
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_to_cnt    <= '0;
         r_shift     <= '0;
         r_parity    <= 1'b0;
         r_stop      <= 1'b0;
         r_ext_pend  <= 1'b0;
         r_brk_pend  <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push <= 1'b0;
         // Clear first so a same-cycle error below takes priority
         if (clr_err) begin
            r_frame_err <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               r_bit_cnt <= '0;
               r_to_cnt  <= '0;
               if (w_fall && !w_data) begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_fall) begin
                  r_to_cnt  <= '0;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt < 4'd8) begin
                     r_shift <= {w_data, r_shift[7:1]};
                  end else if (r_bit_cnt == 4'd8) begin
                     r_parity <= w_data;
                  end else begin
                     r_stop  <= w_data;
                     r_state <= ST_CHECK;
                  end
               end else if (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1)) begin
                  r_state     <= ST_IDLE;
                  r_bit_cnt   <= '0;
                  r_to_cnt    <= '0;
                  r_frame_err <= 1'b1;
                  r_ext_pend  <= 1'b0;
                  r_brk_pend  <= 1'b0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               r_state   <= ST_IDLE;
               r_bit_cnt <= '0;
               if (frame_ok(r_shift, r_parity, r_stop)) begin
                  if (r_shift == PS2_EXT) begin
                     r_ext_pend <= 1'b1;
                  end else if (r_shift == PS2_BRK) begin
                     r_brk_pend <= 1'b1;
                  end else begin
                     r_push      <= 1'b1;
                     r_push_data <= '{ext: r_ext_pend, brk: r_brk_pend, code: r_shift};
                     r_ext_pend  <= 1'b0;
                     r_brk_pend  <= 1'b0;
                  end
               end else begin
                  r_frame_err <= 1'b1;
                  r_ext_pend  <= 1'b0;
                  r_brk_pend  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky overflow: a dropped push wins over a same-cycle clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_err) begin
         r_overflow <= 1'b0;
      end
   end

   assign w_pop = ev_valid & ev_ready;

   ps2_event_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (r_push),
      .push_data (r_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (fifo_count),
      .drop      (w_drop)
   );

   assign ev_valid  = (fifo_count != '0);
   assign ev_code   = w_head.code;
   assign ev_brk    = w_head.brk;
   assign ev_ext    = w_head.ext;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_rx
//  Description : Directed self-checking bench for ps2_kbd_rx (default
//                parameters, deglitch filter disabled).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

   localparam int c_DEPTH   = 8;
   localparam int c_TIMEOUT = 5000;

   logic       clk = 1'b0;
   logic       resetn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_brk;
   logic       ev_ext;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       frame_err;
   logic       clr_err;

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 0;

   ps2_kbd_rx #(
      .FIFO_DEPTH  (c_DEPTH),
      .TIMEOUT_CYC (c_TIMEOUT),
      .SYNC_STAGES (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_brk     (ev_brk),
      .ev_ext     (ev_ext),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 1: record cycles from ps2_clk fall to ev_valid
   // mode 2: pulse ev_ready exactly in the FIFO write cycle of this frame
   task automatic send_bit(input logic b, input int mode);
      ps2_data = b;
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (mode == 1 && ev_valid && lat == 0) lat = i;
         if (mode == 2 && i == 4) ev_ready = 1'b1;
         if (mode == 2 && i == 5) ev_ready = 1'b0;
      end
      ps2_clk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad, input int mode);
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(code[i], 0);
      send_bit(~(^code) ^ bad, 0);
      lat = 0;
      send_bit(1'b1, mode);
   endtask

   task automatic pop_chk(input string tag, input logic e, input logic b, input logic [7:0] c);
      chk({tag, "_valid"}, ev_valid, 1);
      chk({tag, "_code"}, ev_code, c);
      chk({tag, "_brk"}, ev_brk, b);
      chk({tag, "_ext"}, ev_ext, e);
      ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
   endtask

   initial begin
      resetn   = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      ev_ready = 1'b0;
      clr_err  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_valid", ev_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_code", ev_code, 0);
      chk("rst_brk", ev_brk, 0);
      chk("rst_ext", ev_ext, 0);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Single make code, latency: 3 sync + CHECK + FIFO write = 5 cycles
      send_frame(8'h1C, 1'b0, 1);
      chk("lat_1c", lat, 5);
      chk("cnt_1c", fifo_count, 1);
      pop_chk("ev_1c", 1'b0, 1'b0, 8'h1C);
      chk("cnt_after_pop", fifo_count, 0);

      // Break prefix, then extended break
      send_frame(8'hF0, 1'b0, 0);
      chk("cnt_prefix_only", fifo_count, 0);
      send_frame(8'h1C, 1'b0, 0);
      chk("cnt_brk", fifo_count, 1);
      pop_chk("ev_brk1c", 1'b0, 1'b1, 8'h1C);
      send_frame(8'hE0, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h75, 1'b0, 0);
      chk("cnt_extbrk", fifo_count, 1);
      pop_chk("ev_e0f075", 1'b1, 1'b1, 8'h75);

      // Parity error, pending prefix cleared by the error
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b1, 0);
      chk("perr_ferr", frame_err, 1);
      chk("perr_cnt", fifo_count, 0);
      send_frame(8'h32, 1'b0, 0);
      pop_chk("ev_32", 1'b0, 1'b0, 8'h32);
      pulse_clr();
      chk("clr_ferr", frame_err, 0);

      // Timeout after 5 bits
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      repeat (4000) @(posedge clk);
      #1;
      chk("to_not_yet", frame_err, 0);
      repeat (1001) @(posedge clk);
      #1;
      chk("to_ferr", frame_err, 1);
      chk("to_cnt", fifo_count, 0);
      send_frame(8'h5A, 1'b0, 0);
      pop_chk("ev_after_to", 1'b0, 1'b0, 8'h5A);
      pulse_clr();

      // Overflow with consumer stalled
      for (int i = 0; i < c_DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 0);
      chk("full_cnt", fifo_count, c_DEPTH);
      chk("full_no_ovf", overflow, 0);
      send_frame(8'h18, 1'b0, 0);
      chk("ovf_cnt", fifo_count, c_DEPTH);
      chk("ovf_flag", overflow, 1);
      for (int i = 0; i < c_DEPTH; i++) pop_chk("ovf_pop", 1'b0, 1'b0, 8'h10 + 8'(i));
      chk("ovf_empty", fifo_count, 0);
      pulse_clr();
      chk("ovf_clr", overflow, 0);

      // Push and pop in the same cycle while full
      for (int i = 0; i < c_DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b0, 0);
      chk("full2_cnt", fifo_count, c_DEPTH);
      send_frame(8'h28, 1'b0, 2);
      chk("pp_cnt", fifo_count, c_DEPTH);
      chk("pp_ovf", overflow, 0);
      for (int i = 1; i <= c_DEPTH; i++) pop_chk("pp_pop", 1'b0, 1'b0, 8'h20 + 8'(i));
      chk("pp_empty", fifo_count, 0);

      // Reset in the middle of a frame
      send_bit(1'b0, 0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (c_TIMEOUT + 100) @(posedge clk);
      #1;
      chk("midrst_ferr", frame_err, 0);
      chk("midrst_cnt", fifo_count, 0);
      send_frame(8'h1C, 1'b0, 0);
      pop_chk("ev_after_rst", 1'b0, 1'b0, 8'h1C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
